dcache_nway: RTL and testbench



---
 rtl/dcache_nway.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_nway.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// Blocking write-back, write-allocate N-way set-associative data cache with tree PLRU.
// Tag/data arrays: async read, sync write; valid/dirty/PLRU state lives in flops.
module dcache_nway #(
    parameter int WAY_CNT    = 4,
    parameter int INDEX_LEN  = 7,
    parameter int OFFSET_LEN = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_last,
    input  logic        mem_wr_ready
);
    localparam int TAG_LEN    = 32 - INDEX_LEN - OFFSET_LEN;
    localparam int WORD_LEN   = OFFSET_LEN - 2;
    localparam int LINE_WORDS = 1 << WORD_LEN;
    localparam int SETS       = 1 << INDEX_LEN;
    localparam int WAY_LEN    = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int LVL        = $clog2(WAY_CNT);
    localparam int PLRU_W     = (WAY_CNT > 1) ? WAY_CNT - 1 : 1;

    typedef enum logic [1:0] {IDLE, WB, REFILL, INSTALL} state_t;

    logic [TAG_LEN-1:0] tag_mem  [WAY_CNT][SETS];
    logic [31:0]        data_mem [WAY_CNT][SETS*LINE_WORDS];

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]          wen_q, wen_d;
    logic [WAY_LEN-1:0]  vic_q, vic_d;
    logic [31:0]         line_q [LINE_WORDS];
    logic [31:0]         line_d [LINE_WORDS];
    logic [WAY_CNT-1:0]  valid_q [SETS];
    logic [WAY_CNT-1:0]  valid_d [SETS];
    logic [WAY_CNT-1:0]  dirty_q [SETS];
    logic [WAY_CNT-1:0]  dirty_d [SETS];
    logic [PLRU_W-1:0]   plru_q [SETS];
    logic [PLRU_W-1:0]   plru_d [SETS];

    // Heap-ordered tree: node n has bit n-1; 0 sends the victim search left, 1 right.
    function automatic logic [WAY_LEN-1:0] plru_victim(input logic [PLRU_W-1:0] b);
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) node = 2 * node + int'(b[node-1]);
        return WAY_LEN'(node - WAY_CNT);
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                     input logic [WAY_LEN-1:0] w);
        logic [PLRU_W-1:0] r;
        int node;
        r    = b;
        node = int'(w) + WAY_CNT;
        for (int l = 0; l < LVL; l++) begin
            r[(node >> 1) - 1] = ~node[0];
            node = node >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Outside IDLE the CPU holds its request, but the latched copy is authoritative.
    logic [31:0]          acc_addr;
    logic [TAG_LEN-1:0]   tag;
    logic [INDEX_LEN-1:0] idx;
    logic [WORD_LEN-1:0]  word;
    logic [WAY_CNT-1:0]   hit_vec;
    logic [WAY_LEN-1:0]   hit_way, victim;
    logic                 hit, hit_wr;
    logic [31:0]          hit_word;

    always_comb begin
        acc_addr = (state_q == IDLE) ? cpu_addr : addr_q;
        tag      = acc_addr[31 -: TAG_LEN];
        idx      = acc_addr[OFFSET_LEN +: INDEX_LEN];
        word     = acc_addr[OFFSET_LEN-1:2];
        hit_way  = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_mem[w][idx] == tag);
            if (hit_vec[w]) hit_way = WAY_LEN'(w);
        end
        hit      = |hit_vec;
        hit_word = data_mem[hit_way][{idx, word}];
        hit_wr   = resetn && (state_q == IDLE) && cpu_req && hit && (|cpu_wen);
        victim   = plru_victim(plru_q[idx]);
        for (int w = WAY_CNT - 1; w >= 0; w--) if (!valid_q[idx][w]) victim = WAY_LEN'(w);
    end

    always_comb begin
        cpu_stall   = (state_q != IDLE) || (cpu_req && !hit);
        cpu_rdata   = (state_q == IDLE && cpu_req && hit) ? hit_word : '0;
        mem_rd_req  = (state_q == REFILL);
        mem_rd_addr = mem_rd_req ? {addr_q[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}} : '0;
        mem_wr_req  = (state_q == WB);
        mem_wr_addr = mem_wr_req ? {tag_mem[vic_q][idx], idx, {OFFSET_LEN{1'b0}}} : '0;
        mem_wr_data = mem_wr_req ? data_mem[vic_q][{idx, cnt_q}] : '0;
        mem_wr_last = mem_wr_req && (&cnt_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        vic_d   = vic_q;
        line_d  = line_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;
        case (state_q)
            IDLE: if (cpu_req) begin
                if (hit) begin
                    plru_d[idx] = plru_touch(plru_q[idx], hit_way);
                    if (|cpu_wen) dirty_d[idx][hit_way] = 1'b1;
                end else begin
                    addr_d  = cpu_addr;
                    wen_d   = cpu_wen;
                    wdata_d = cpu_wdata;
                    vic_d   = victim;
                    cnt_d   = '0;
                    state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WB : REFILL;
                end
            end
            WB: if (mem_wr_ready) begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = REFILL;
            end
            REFILL: if (mem_rd_valid) begin
                line_d[cnt_q] = mem_rd_data;
                cnt_d         = cnt_q + 1'b1;
                if (&cnt_q) state_d = INSTALL;
            end
            INSTALL: begin
                valid_d[idx][vic_q] = 1'b1;
                dirty_d[idx][vic_q] = |wen_q;
                plru_d[idx]         = plru_touch(plru_q[idx], vic_q);
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            vic_q   <= '0;
            line_q  <= '{default: '0};
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            vic_q   <= vic_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            plru_q  <= plru_d;
        end
    end

    // The pending store is folded into the refilled line so the replayed request just hits.
    always_ff @(posedge clk) begin
        if (hit_wr) data_mem[hit_way][{idx, word}] <= merge(hit_word, cpu_wdata, cpu_wen);
        if (resetn && state_q == INSTALL) begin
            tag_mem[vic_q][idx] <= tag;
            for (int i = 0; i < LINE_WORDS; i++)
                data_mem[vic_q][{idx, WORD_LEN'(i)}] <= (WORD_LEN'(i) == word)
                    ? merge(line_q[i], wdata_q, wen_q) : line_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && state_q == IDLE && cpu_req) assert ($onehot0(hit_vec));
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench: a scoreboard of expected load data against a shadow memory, with the
// bench acting as the memory bridge (refill gaps, randomly toggled write-back ready).
module tb_dcache_nway;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_rd_req, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        mem_wr_req, mem_wr_last, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;

    dcache_nway dut (
        .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
        .mem_wr_ready(mem_wr_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] bmem   [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] sb [$];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        if (a[31:5] == 27'h80) return 32'hA0 + {29'b0, a[4:2]};
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : def_word(a);
    endfunction

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : def_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access; the bench plays the bridge until the cache stops stalling.
    task automatic access(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                          input int gapmax, input bit rdy_rand,
                          output int stalls, output int wbn, output int rdn,
                          output logic [31:0] wb_a);
        int gap;
        logic [31:0] exp, nw;
        cpu_req = 1'b1; cpu_addr = a; cpu_wen = wen; cpu_wdata = wd;
        if (wen == 4'b0) sb.push_back(sh_rd(a));
        stalls = 0; wbn = 0; rdn = 0; gap = 0; wb_a = '0;
        #1;
        while (cpu_stall && stalls < 400) begin
            stalls++;
            mem_rd_valid = 1'b0;
            mem_wr_ready = 1'b0;
            if (mem_wr_req) begin
                mem_wr_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
                if (mem_wr_ready) begin
                    wb_a = mem_wr_addr;
                    check("wb_data", mem_wr_data, sh_rd(mem_wr_addr + 32'(4 * wbn)));
                    check("wb_last", {31'b0, mem_wr_last}, {31'b0, wbn == 7});
                    bmem[mem_wr_addr + 32'(4 * wbn)] = mem_wr_data;
                    wbn++;
                end
            end
            if (mem_rd_req && rdn < 8) begin
                if (gap == 0) begin
                    check("rd_addr", mem_rd_addr, {a[31:5], 5'b0});
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = bm_rd(mem_rd_addr + 32'(4 * rdn));
                    rdn++;
                    gap = int'($urandom_range(gapmax));
                end else gap--;
            end
            @(negedge clk); #1;
        end
        mem_rd_valid = 1'b0;
        mem_wr_ready = 1'b0;
        if (stalls >= 400) begin
            check("timeout", 32'(stalls), 32'd0);
            if (wen == 4'b0) void'(sb.pop_front());
        end else if (wen == 4'b0) begin
            exp = sb.pop_front();
            check("rdata", cpu_rdata, exp);
        end else begin
            nw = sh_rd(a);
            for (int i = 0; i < 4; i++) if (wen[i]) nw[8*i +: 8] = wd[8*i +: 8];
            shadow[a] = nw;
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    int st, wb, rd, n;
    logic [31:0] wa;

    initial begin
        resetn = 1'b0; cpu_req = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_rd_req", {31'b0, mem_rd_req}, 32'd0);
        check("rst_wr_req", {31'b0, mem_wr_req}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Cold read: 8 beats + 2 cycles of stall, then an immediate hit on the same line.
        access(32'h1004, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("cold_lat", 32'(st), 32'd10);
        check("cold_rdn", 32'(rd), 32'd8);
        access(32'h1000, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("hit_lat", 32'(st), 32'd0);

        // Write hit with byte merge, no memory traffic.
        access(32'h1008, 4'b0101, 32'h1122_3344, 0, 0, st, wb, rd, wa);
        check("wh_lat", 32'(st), 32'd0);
        check("wh_traffic", 32'(wb + rd), 32'd0);
        access(32'h1008, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("wh_merge", sh_rd(32'h1008), 32'h0022_0044);

        // Write miss: refill then merge on install.
        access(32'h2010, 4'b1111, 32'hDEAD_BEEF, 0, 0, st, wb, rd, wa);
        check("wm_rdn", 32'(rd), 32'd8);
        check("wm_wbn", 32'(wb), 32'd0);
        access(32'h2010, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("wm_hit", 32'(st), 32'd0);

        // Fill set 0, then the fifth tag evicts dirty way 0 (tag 1).
        access(32'h3000, 4'b0, 0, 0, 0, st, wb, rd, wa);
        access(32'h4000, 4'b0, 0, 0, 0, st, wb, rd, wa);
        access(32'h5000, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("ev_wbn", 32'(wb), 32'd8);
        check("ev_wba", wa, 32'h1000);
        check("ev_lat", 32'(st), 32'd18);
        access(32'h1008, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("rb_rdn", 32'(rd), 32'd8);
        check("rb_wbn", 32'(wb), 32'd0);

        // Refill gaps and ready toggling: evicts dirty tag 2 line, then re-reads it.
        access(32'h6004, 4'b0, 0, 3, 1, st, wb, rd, wa);
        check("gap_wbn", 32'(wb), 32'd8);
        check("gap_wba", wa, 32'h2000);
        access(32'h2010, 4'b0, 0, 3, 1, st, wb, rd, wa);
        check("gap_rdn", 32'(rd), 32'd8);
        access(32'h6000, 4'b0, 0, 3, 1, st, wb, rd, wa);

        // Reset in the middle of a refill.
        cpu_req = 1'b1; cpu_addr = 32'h7000; cpu_wen = '0; n = 0;
        #1;
        repeat (5) begin
            mem_rd_valid = mem_rd_req;
            if (mem_rd_req) begin
                mem_rd_data = bm_rd(32'h7000 + 32'(4 * n));
                n++;
            end
            @(negedge clk); #1;
        end
        check("mid_rd_req", {31'b0, mem_rd_req}, 32'd1);
        mem_rd_valid = 1'b0; resetn = 1'b0; cpu_req = 1'b0;
        @(negedge clk); #1;
        resetn = 1'b1;
        check("mr_rd_req", {31'b0, mem_rd_req}, 32'd0);
        check("mr_stall", {31'b0, cpu_stall}, 32'd0);
        check("mr_wr_req", {31'b0, mem_wr_req}, 32'd0);
        shadow = bmem;
        @(negedge clk);
        access(32'h7000, 4'b0, 0, 0, 0, st, wb, rd, wa);
        check("mr_rdn", 32'(rd), 32'd8);
        access(32'h1008, 4'b0, 0, 2, 0, st, wb, rd, wa);
        check("mr_rdn2", 32'(rd), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
